// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external single-port memory bus between instruction fetch (IF)
// and the MEM-stage data access (DM). DM has fixed priority over IF. Each
// access is issue -> wait for bus_ack -> one DONE cycle, and the pipeline
// receives stall requests until its data is ready. An access that is never
// acknowledged is aborted after TIMEOUT busy cycles. A bus_err pulse is
// raised in that case, and zero is returned as the read data.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   flush                 pipeline flush, discards a pending fetch result
//   if_ce, if_addr        fetch request (word read)
//   if_rdata, if_stall    fetched instruction, IF stall request
//   dm_ce, dm_we, dm_sel,
//   dm_addr, dm_wdata     data request (big-endian byte lanes in dm_sel)
//   dm_rdata, dm_stall    load data, MEM stall request
//   bus_req/we/sel/addr/
//   bus_wdata             registered bus request, held until bus_ack
//   bus_rdata, bus_ack    bus read data, valid with the single-cycle ack
//   bus_err               one-cycle pulse when an access times out
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              if_ce,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_ce,
   input  logic              dm_we,
   input  logic [3:0]        dm_sel,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err
);

   typedef enum logic [2:0] {IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [3:0]        bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              bus_err_q, bus_err_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              discard_q, discard_d;
   logic              busy;
   logic              timeout_hit;

   // The counter holds the number of busy cycles already spent. When it shows
   // TIMEOUT-1 and no ack arrives, this cycle is the TIMEOUT-th busy cycle.
   assign busy        = (state_q == D_BUSY) || (state_q == I_BUSY);
   assign timeout_hit = busy && !bus_ack && (cnt_q == TIMEOUT_LAST);

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_err_q   <= 1'b0;
         dm_rdata_q  <= '0;
         if_rdata_q  <= '0;
         discard_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
         dm_rdata_q  <= dm_rdata_d;
         if_rdata_q  <= if_rdata_d;
         discard_q   <= discard_d;
      end
   end

   // Next state: DM wins in IDLE, busy ends on ack or timeout, DONE lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dm_ce) begin
               state_d = D_BUSY;
            end else if (if_ce && !flush) begin
               state_d = I_BUSY;
            end
         end
         D_BUSY:  if (bus_ack || timeout_hit) state_d = D_DONE;
         I_BUSY:  if (bus_ack || timeout_hit) state_d = I_DONE;
         D_DONE:  state_d = IDLE;
         I_DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus issue, timeout counting and read-data capture
   always_comb begin
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_err_d   = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      if_rdata_d  = if_rdata_q;
      discard_d   = discard_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (dm_ce) begin
               bus_req_d   = 1'b1;
               bus_we_d    = dm_we;
               bus_sel_d   = dm_sel;
               bus_addr_d  = dm_addr;
               bus_wdata_d = dm_wdata;
            end else if (if_ce && !flush) begin
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_sel_d  = 4'b1111;
               bus_addr_d = if_addr;
            end
         end
         D_BUSY, I_BUSY: begin
            // A flush during a fetch lets the handshake finish but drops its
            // result. A flush in the ack cycle itself also counts.
            if (state_q == I_BUSY && flush) begin
               discard_d = 1'b1;
            end
            if (bus_ack || timeout_hit) begin
               bus_req_d = 1'b0;
               cnt_d     = '0;
               bus_err_d = timeout_hit;
               if (state_q == D_BUSY) begin
                  if (!bus_we_q) begin
                     dm_rdata_d = bus_ack ? bus_rdata : '0;
                  end
               end else if (!(discard_q || flush)) begin
                  if_rdata_d = bus_ack ? bus_rdata : '0;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         I_DONE:  discard_d = 1'b0;
         default: ;
      endcase
   end

   // Stall requests: DM holds IF off for as long as it owns or wants the bus
   always_comb begin
      dm_stall = dm_ce && (state_q != D_DONE);
      if_stall = (if_ce && (state_q != I_DONE) && !flush) ||
                 (dm_ce && ((state_q == IDLE) || (state_q == D_BUSY) || (state_q == D_DONE)));
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_sel   = bus_sel_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_err   = bus_err_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_rdata  = if_rdata_q;

endmodule
